// File: rtl/common_pkg.sv
// Shared types for the memory bus arbiter: FSM states, bus owner identity,
// and the width of the wait-cycle counter.
package common_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } arb_state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_EXT
  } arb_owner_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU and an external
// loader/debug master; each transfer is IDLE -> ACCESS (WAIT_CYCLES+1) -> DONE.
module mem_bus_arbiter
  import common_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  input  logic [15:0] i_cpu_addr,
  input  logic [15:0] i_cpu_wdata,
  output logic [15:0] o_cpu_rdata,
  output logic        o_cpu_stall,
  input  logic        i_ext_req,
  input  logic        i_ext_we,
  input  logic [15:0] i_ext_addr,
  input  logic [15:0] i_ext_wdata,
  output logic        o_ext_ack,
  output logic [15:0] o_ext_rdata,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_mem_we,
  output logic        o_mem_oe,
  input  logic [15:0] i_mem_rdata,
  output logic        o_err
);

  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, last_q, grant_owner;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      addr_q, wdata_q, cpu_rdata_q, ext_rdata_q;
  logic             we_q, err_q, grant, cpu_pend;

  assign cpu_pend    = i_cpu_rd | i_cpu_wr;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_cpu_rdata = cpu_rdata_q;
  assign o_ext_rdata = ext_rdata_q;
  assign o_err       = err_q;

  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    grant_owner = OWN_CPU;
    o_mem_we    = 1'b0;
    o_mem_oe    = 1'b0;
    o_ext_ack   = 1'b0;
    o_cpu_stall = cpu_pend;
    case (state_q)
      IDLE: begin
        if (cpu_pend || i_ext_req) begin
          grant   = 1'b1;
          state_d = ACCESS;
          // EXT wins only when alone or when the CPU held the bus last
          if (i_ext_req && (!cpu_pend || last_q == OWN_CPU)) grant_owner = OWN_EXT;
        end
      end
      ACCESS: begin
        o_mem_we = we_q;
        o_mem_oe = ~we_q;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        state_d     = IDLE;
        o_ext_ack   = (owner_q == OWN_EXT);
        o_cpu_stall = cpu_pend && (owner_q != OWN_CPU);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      last_q      <= OWN_EXT;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      if (grant) begin
        owner_q <= grant_owner;
        last_q  <= grant_owner;
        cnt_q   <= CNT_W'(WAIT_CYCLES);
        if (grant_owner == OWN_EXT) begin
          addr_q  <= i_ext_addr;
          wdata_q <= i_ext_wdata;
          we_q    <= i_ext_we;
        end else begin
          // simultaneous rd+wr is resolved as a write and flagged
          addr_q  <= i_cpu_addr;
          wdata_q <= i_cpu_wdata;
          we_q    <= i_cpu_wr;
          err_q   <= i_cpu_rd & i_cpu_wr;
        end
      end else if (state_q == ACCESS) begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q == OWN_CPU) cpu_rdata_q <= i_mem_rdata;
            else                    ext_rdata_q <= i_mem_rdata;
          end
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (WAIT_CYCLES=1 and 0) share inputs;
// directed table, corner-case sequences, then random traffic vs a transaction model.
module tb_mem_bus_arbiter;
  import common_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_rd, cpu_wr, ext_req, ext_we;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata, mem_rdata;

  logic [15:0] cpu_rdata [2];
  logic [15:0] ext_rdata [2];
  logic [15:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic        cpu_stall [2];
  logic        ext_ack   [2];
  logic        mem_we    [2];
  logic        mem_oe    [2];
  logic        err       [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata[0]), .o_cpu_stall(cpu_stall[0]),
    .i_ext_req(ext_req), .i_ext_we(ext_we), .i_ext_addr(ext_addr), .i_ext_wdata(ext_wdata),
    .o_ext_ack(ext_ack[0]), .o_ext_rdata(ext_rdata[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]), .o_mem_we(mem_we[0]),
    .o_mem_oe(mem_oe[0]), .i_mem_rdata(mem_rdata), .o_err(err[0])
  );

  mem_bus_arbiter #(.WAIT_CYCLES(0)) dut_w0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_rd(cpu_rd), .i_cpu_wr(cpu_wr), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata[1]), .o_cpu_stall(cpu_stall[1]),
    .i_ext_req(ext_req), .i_ext_we(ext_we), .i_ext_addr(ext_addr), .i_ext_wdata(ext_wdata),
    .o_ext_ack(ext_ack[1]), .o_ext_rdata(ext_rdata[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]), .o_mem_we(mem_we[1]),
    .o_mem_oe(mem_oe[1]), .i_mem_rdata(mem_rdata), .o_err(err[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a granted transfer occupies the bus for
  // W+2 cycles (W+1 memory cycles, then one completion cycle).
  int          m_busy    [2];
  bit          m_own_ext [2];
  bit          m_wr      [2];
  bit          m_last_ext[2];
  bit          m_err     [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_wd   [2];
  logic [15:0] m_cr   [2];
  logic [15:0] m_er   [2];

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_own_ext[k] = 0; m_wr[k] = 0; m_last_ext[k] = 1; m_err[k] = 0;
      m_addr[k] = '0; m_wd[k] = '0; m_cr[k] = '0; m_er[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    bit cpu_p, g_ext;
    cpu_p = cpu_rd | cpu_wr;
    m_err[k] = 0;
    if (m_busy[k] == 0) begin
      if (cpu_p || ext_req) begin
        g_ext = ext_req && (!cpu_p || !m_last_ext[k]);
        m_own_ext[k]  = g_ext;
        m_last_ext[k] = g_ext;
        m_addr[k] = g_ext ? ext_addr : cpu_addr;
        m_wd[k]   = g_ext ? ext_wdata : cpu_wdata;
        m_wr[k]   = g_ext ? ext_we : cpu_wr;
        m_err[k]  = !g_ext && cpu_rd && cpu_wr;
        m_busy[k] = wait_of(k) + 2;
      end
    end else begin
      if (m_busy[k] == 2 && !m_wr[k]) begin
        if (m_own_ext[k]) m_er[k] = mem_rdata;
        else              m_cr[k] = mem_rdata;
      end
      m_busy[k]--;
    end
  endtask

  task automatic model_check(input int k);
    bit acc, done;
    acc  = m_busy[k] >= 2;
    done = m_busy[k] == 1;
    chk($sformatf("rnd%0d_stall", k), cpu_stall[k], (cpu_rd | cpu_wr) && !(done && !m_own_ext[k]));
    chk($sformatf("rnd%0d_we", k),    mem_we[k],    acc && m_wr[k]);
    chk($sformatf("rnd%0d_oe", k),    mem_oe[k],    acc && !m_wr[k]);
    chk($sformatf("rnd%0d_ack", k),   ext_ack[k],   done && m_own_ext[k]);
    chk($sformatf("rnd%0d_err", k),   err[k],       m_err[k]);
    chk($sformatf("rnd%0d_addr", k),  mem_addr[k],  m_addr[k]);
    chk($sformatf("rnd%0d_wdata", k), mem_wdata[k], m_wd[k]);
    chk($sformatf("rnd%0d_crd", k),   cpu_rdata[k], m_cr[k]);
    chk($sformatf("rnd%0d_erd", k),   ext_rdata[k], m_er[k]);
  endtask

  task automatic clr_inputs();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; mem_rdata = '0;
  endtask

  // Leaves the bench one time unit after a rising edge, inputs idle.
  task automatic do_reset();
    clr_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  typedef struct {
    logic        rst_n, rd, ereq;
    logic [15:0] caddr, eaddr, mrd;
    logic        stall, oe, we, ack;
    logic [15:0] crd, erd, maddr;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] s_err, s_we, s_oe, s_st;
    logic [3:0] s_ack;
    int         acks;

    //        rst  rd  ereq caddr     eaddr     mrd        stall oe  we  ack crd       erd       maddr
    tbl[0]  = '{1, 1, 0, 16'h0100, 16'h0000, 16'hBEEF,   1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    tbl[1]  = '{1, 1, 0, 16'h0100, 16'h0000, 16'hBEEF,   1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0100};
    tbl[2]  = '{1, 1, 0, 16'h0100, 16'h0000, 16'hBEEF,   1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0100};
    tbl[3]  = '{1, 1, 0, 16'h0100, 16'h0000, 16'hBEEF,   0, 0, 0, 0, 16'hBEEF, 16'h0000, 16'h0100};
    tbl[4]  = '{1, 0, 0, 16'h0100, 16'h0000, 16'hBEEF,   0, 0, 0, 0, 16'hBEEF, 16'h0000, 16'h0100};
    tbl[5]  = '{0, 0, 0, 16'h0000, 16'h0000, 16'h0000,   0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    tbl[6]  = '{1, 1, 1, 16'h0300, 16'h0400, 16'h1111,   1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000};
    tbl[7]  = '{1, 1, 1, 16'h0300, 16'h0400, 16'h1111,   1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0300};
    tbl[8]  = '{1, 1, 1, 16'h0300, 16'h0400, 16'h1111,   1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0300};
    tbl[9]  = '{1, 1, 1, 16'h0300, 16'h0400, 16'h1111,   0, 0, 0, 0, 16'h1111, 16'h0000, 16'h0300};
    tbl[10] = '{1, 0, 1, 16'h0300, 16'h0400, 16'h2222,   0, 0, 0, 0, 16'h1111, 16'h0000, 16'h0300};
    tbl[11] = '{1, 0, 1, 16'h0300, 16'h0400, 16'h2222,   0, 1, 0, 0, 16'h1111, 16'h0000, 16'h0400};
    tbl[12] = '{1, 0, 1, 16'h0300, 16'h0400, 16'h2222,   0, 1, 0, 0, 16'h1111, 16'h0000, 16'h0400};
    tbl[13] = '{1, 1, 1, 16'h0500, 16'h0600, 16'h3333,   1, 0, 0, 1, 16'h1111, 16'h2222, 16'h0400};
    tbl[14] = '{1, 1, 1, 16'h0500, 16'h0600, 16'h3333,   1, 0, 0, 0, 16'h1111, 16'h2222, 16'h0400};
    tbl[15] = '{1, 1, 1, 16'h0500, 16'h0600, 16'h3333,   1, 1, 0, 0, 16'h1111, 16'h2222, 16'h0500};
    tbl[16] = '{1, 1, 1, 16'h0500, 16'h0600, 16'h3333,   1, 1, 0, 0, 16'h1111, 16'h2222, 16'h0500};
    tbl[17] = '{1, 1, 1, 16'h0500, 16'h0600, 16'h3333,   0, 0, 0, 0, 16'h3333, 16'h2222, 16'h0500};
    tbl[18] = '{1, 0, 0, 16'h0500, 16'h0600, 16'h3333,   0, 0, 0, 0, 16'h3333, 16'h2222, 16'h0500};

    // Reset state, checked asynchronously before any clock edge
    clr_inputs();
    rst_n = 0;
    #2;
    chk("rst_state", dut_w1.state_q, IDLE);
    chk("rst_oe", mem_oe[0], 0);
    chk("rst_we", mem_we[0], 0);
    chk("rst_ack", ext_ack[0], 0);
    chk("rst_err", err[0], 0);
    chk("rst_crd", cpu_rdata[0], 16'h0000);
    chk("rst_erd", ext_rdata[0], 16'h0000);
    chk("rst_addr", mem_addr[0], 16'h0000);
    do_reset();

    // Directed table on the WAIT_CYCLES=1 instance
    for (int i = 0; i < NV; i++) begin
      rst_n = tbl[i].rst_n; cpu_rd = tbl[i].rd; ext_req = tbl[i].ereq;
      cpu_addr = tbl[i].caddr; ext_addr = tbl[i].eaddr; mem_rdata = tbl[i].mrd;
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", i), cpu_stall[0], tbl[i].stall);
      chk($sformatf("tbl%0d_oe", i),    mem_oe[0],    tbl[i].oe);
      chk($sformatf("tbl%0d_we", i),    mem_we[0],    tbl[i].we);
      chk($sformatf("tbl%0d_ack", i),   ext_ack[0],   tbl[i].ack);
      chk($sformatf("tbl%0d_crd", i),   cpu_rdata[0], tbl[i].crd);
      chk($sformatf("tbl%0d_erd", i),   ext_rdata[0], tbl[i].erd);
      chk($sformatf("tbl%0d_addr", i),  mem_addr[0],  tbl[i].maddr);
      @(posedge clk); #1;
    end

    // EXT write on the WAIT_CYCLES=0 instance
    do_reset();
    ext_req = 1; ext_we = 1; ext_addr = 16'h0200; ext_wdata = 16'h1234;
    @(negedge clk);
    chk("extw_idle_we", mem_we[1], 0);
    @(posedge clk); #1;
    ext_req = 0;
    s_we = '0; s_ack = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      s_we[c]  = mem_we[1];
      s_ack[c] = ext_ack[1];
      if (c == 0) begin
        chk("extw_addr", mem_addr[1], 16'h0200);
        chk("extw_wdata", mem_wdata[1], 16'h1234);
      end
      @(posedge clk); #1;
    end
    chk("extw_we_seq", s_we[3:0], 4'b0001);
    chk("extw_ack_seq", s_ack, 4'b0010);

    // CPU rd+wr together: write performed, error pulse on ACCESS entry
    do_reset();
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 16'h0700; cpu_wdata = 16'hA5A5;
    s_err = '0; s_we = '0; s_oe = '0; s_st = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      s_err[c] = err[0]; s_we[c] = mem_we[0]; s_oe[c] = mem_oe[0]; s_st[c] = cpu_stall[0];
      @(posedge clk); #1;
      if (c == 3) begin cpu_rd = 0; cpu_wr = 0; end
    end
    chk("rdwr_err_seq", s_err, 5'b00010);
    chk("rdwr_we_seq", s_we, 5'b00110);
    chk("rdwr_oe_seq", s_oe, 5'b00000);
    chk("rdwr_stall_seq", s_st, 5'b00111);
    chk("rdwr_wdata", mem_wdata[0], 16'hA5A5);

    // Reset during the second ACCESS cycle of an EXT read
    do_reset();
    ext_req = 1; ext_we = 0; ext_addr = 16'h0800; mem_rdata = 16'hCAFE;
    @(posedge clk); #1;
    ext_req = 0;
    @(negedge clk);
    chk("rstmid_oe1", mem_oe[0], 1);
    @(posedge clk); #1;
    chk("rstmid_oe2", mem_oe[0], 1);
    rst_n = 0;
    #1;
    chk("rstmid_oe_async", mem_oe[0], 0);
    chk("rstmid_addr_async", mem_addr[0], 16'h0000);
    chk("rstmid_state_async", dut_w1.state_q, IDLE);
    @(posedge clk); #1;
    rst_n = 1;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ext_ack[0]) acks++;
      @(posedge clk); #1;
    end
    chk("rstmid_no_ack", acks, 0);
    chk("rstmid_erd", ext_rdata[0], 16'h0000);
    chk("rstmid_state", dut_w1.state_q, IDLE);

    // EXT address/data changed mid-transfer must not disturb the bus
    do_reset();
    ext_req = 1; ext_we = 1; ext_addr = 16'h0900; ext_wdata = 16'h5555;
    @(posedge clk); #1;
    ext_req = 0; ext_addr = 16'h0ABC; ext_wdata = 16'hFFFF;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_addr", c), mem_addr[0], 16'h0900);
      chk($sformatf("hold%0d_wdata", c), mem_wdata[0], 16'h5555);
      chk($sformatf("hold%0d_we", c), mem_we[0], 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("hold_done_addr", mem_addr[0], 16'h0900);
    chk("hold_done_ack", ext_ack[0], 1);
    @(posedge clk); #1;

    // Random traffic on both instances against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      cpu_rd    = ($urandom_range(0, 2) == 0);
      cpu_wr    = ($urandom_range(0, 3) == 0);
      ext_req   = ($urandom_range(0, 2) == 0);
      ext_we    = $urandom_range(0, 1);
      cpu_addr  = 16'($urandom); cpu_wdata = 16'($urandom);
      ext_addr  = 16'($urandom); ext_wdata = 16'($urandom);
      mem_rdata = 16'($urandom);
      @(negedge clk);
      if (!rst_n) model_reset();
      for (int k = 0; k < 2; k++) begin
        model_check(k);
        if (rst_n) model_step(k);
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
